// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the AES-128 decryptor datapath (INIT ARK, middle rounds, final round).
// Latency: handshake at T -> out_valid at T+3+(ROUNDS-1)*(1+IMC_LAT) (T+21 with defaults).
// Backpressure: DONE holds out_valid with stable rk_idx/dp_sel until out_ready; in_ready low while busy.
//
// Ports:
//   clk, rst (async active-low), clr (sync abort back to IDLE)
//   in_valid/in_ready   : ciphertext block handshake; dp_load = in_valid & in_ready
//   out_valid/out_ready : plaintext completion handshake
//   dp_sel    : 0=INIT (ct^rk), 1=ROUND (InvMixColumns path), 2=FINAL (no InvMixColumns)
//   rk_idx    : round-key index to the key store (ROUNDS..0)
//   state_we  : datapath state register write enable
//   busy      : high in every state except IDLE
//
// Optional build macro AES_CTRL_OVERLAP_EN: in DONE, in_ready follows out_ready so a new
// block is accepted in the same cycle the result is taken, skipping the IDLE cycle.
module aes_dec_round_ctrl #(
  parameter int ROUNDS  = 10,
  parameter int IMC_LAT = 1,
  parameter int RK_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            dp_load,
  output logic [1:0]      dp_sel,
  output logic [RK_W-1:0] rk_idx,
  output logic            state_we,
  output logic            busy
);

  localparam int WC_W = (IMC_LAT > 1) ? $clog2(IMC_LAT) : 1;

  localparam logic [1:0] SEL_INIT  = 2'd0;
  localparam logic [1:0] SEL_ROUND = 2'd1;
  localparam logic [1:0] SEL_FINAL = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    RND_ISSUE = 3'd2,
    RND_WAIT  = 3'd3,
    FINAL     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [RK_W-1:0] rnd, rnd_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;

  // State, round and wait counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rnd   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state and output decode. Outputs depend on registered state/rnd/wcnt,
  // except in_ready (DONE, overlap build) and dp_load which look at the handshake inputs.
  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    wcnt_nxt  = wcnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_sel    = SEL_INIT;
    rk_idx    = '0;
    state_we  = 1'b0;
    busy      = 1'b1;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = INIT;
        end
      end

      INIT: begin
        dp_sel    = SEL_INIT;
        rk_idx    = RK_W'(ROUNDS);
        state_we  = 1'b1;
        rnd_nxt   = RK_W'(ROUNDS - 1);
        state_nxt = RND_ISSUE;
      end

      // InvMixColumns captures the AddRoundKey result this cycle; the state
      // register is written only once the registered result is available.
      RND_ISSUE: begin
        dp_sel    = SEL_ROUND;
        rk_idx    = rnd;
        wcnt_nxt  = WC_W'(IMC_LAT - 1);
        state_nxt = RND_WAIT;
      end

      RND_WAIT: begin
        dp_sel = SEL_ROUND;
        rk_idx = rnd;
        if (wcnt == '0) begin
          state_we = 1'b1;
          if (rnd == RK_W'(1)) begin
            state_nxt = FINAL;
          end else begin
            rnd_nxt   = rnd - RK_W'(1);
            state_nxt = RND_ISSUE;
          end
        end else begin
          wcnt_nxt = wcnt - WC_W'(1);
        end
      end

      FINAL: begin
        dp_sel    = SEL_FINAL;
        rk_idx    = '0;
        state_we  = 1'b1;
        state_nxt = DONE;
      end

      DONE: begin
        // dp_sel/rk_idx stay at the decode defaults, so they are stable while stalled.
        out_valid = 1'b1;
`ifdef AES_CTRL_OVERLAP_EN
        in_ready = out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? INIT : IDLE;
        end
`else
        in_ready = 1'b0;
        if (out_ready) begin
          state_nxt = IDLE;
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort wins over everything; outputs above still reflect the current state.
    if (clr) begin
      state_nxt = IDLE;
      rnd_nxt   = '0;
      wcnt_nxt  = '0;
    end
  end

  assign dp_load = in_valid & in_ready;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: directed scenarios plus random handshakes,
// checked every cycle against a cycle-offset schedule model of the round sequence.
module tb_aes_dec_round_ctrl;

  localparam int R   = 10;
  localparam int L   = 1;
  localparam int LAT = 3 + (R - 1) * (1 + L);
`ifdef AES_CTRL_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, dp_load, state_we, busy;
  logic [1:0] dp_sel;
  logic [3:0] rk_idx;

  aes_dec_round_ctrl #(.ROUNDS(R), .IMC_LAT(L), .RK_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .dp_load(dp_load), .dp_sel(dp_sel), .rk_idx(rk_idx),
    .state_we(state_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // Model: m_off = 0 when idle, otherwise cycles elapsed since the block was accepted
  // (saturating at LAT, which means result waiting for the consumer).
  int m_off = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit lat_pend = 1'b0;

  int e_ir, e_ov, e_ld, e_sel, e_rk, e_we, e_busy;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_expect(input logic iv, input logic ordy);
    int j;
    e_ir = 0; e_ov = 0; e_sel = 0; e_rk = 0; e_we = 0; e_busy = 1;
    if (m_off == 0) begin
      e_ir = 1; e_busy = 0;
    end else if (m_off == 1) begin
      e_rk = R; e_we = 1;
    end else if (m_off < LAT - 1) begin
      j     = m_off - 2;
      e_sel = 1;
      e_rk  = R - 1 - j / (1 + L);
      e_we  = ((j % (1 + L)) == L) ? 1 : 0;
    end else if (m_off == LAT - 1) begin
      e_sel = 2; e_we = 1;
    end else begin
      e_ov = 1;
      e_ir = OVL ? int'(ordy) : 0;
    end
    e_ld = (iv && e_ir != 0) ? 1 : 0;
  endtask

  task automatic check_outputs(input logic iv, input logic ordy);
    model_expect(iv, ordy);
    chk("in_ready", int'(in_ready), e_ir);
    chk("out_valid", int'(out_valid), e_ov);
    chk("dp_load", int'(dp_load), e_ld);
    chk("dp_sel", int'(dp_sel), e_sel);
    chk("rk_idx", int'(rk_idx), e_rk);
    chk("state_we", int'(state_we), e_we);
    chk("busy", int'(busy), e_busy);
    if (out_valid && lat_pend) begin
      chk("latency", cyc - acc_cyc, LAT);
      lat_pend = 1'b0;
    end
  endtask

  // One clock: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic iv, input logic ordy, input logic c);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    clr       = c;
    #1;
    check_outputs(iv, ordy);
    @(posedge clk);
    if (c) begin
      m_off    = 0;
      lat_pend = 1'b0;
    end else begin
      if (e_ld != 0) begin
        acc_cyc  = cyc;
        lat_pend = 1'b1;
      end
      if (m_off == 0) begin
        if (iv) m_off = 1;
      end else if (m_off < LAT) begin
        m_off++;
      end else if (ordy) begin
        m_off = (OVL && iv) ? 1 : 0;
      end
    end
    cyc++;
  endtask

  initial begin
    // Reset state.
    #3;
    check_outputs(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single block accepted at T=5 with the consumer ready.
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (LAT + 3) step(1'b0, 1'b1, 1'b0);

    // Backpressure: consumer stalls 7 cycles while a new block is offered.
    step(1'b1, 1'b1, 1'b0);
    repeat (LAT - 1) step(1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);

    // Abort in RND_WAIT with rnd=5, then a full block afterwards.
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (LAT + 2) step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset during RND_ISSUE with rnd=3.
    step(1'b1, 1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_outputs(1'b0, 1'b1);
    rst = 1'b0;
    #1;
    m_off    = 0;
    lat_pend = 1'b0;
    check_outputs(1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Continuous traffic with the consumer always ready.
    repeat (100) step(1'b1, 1'b1, 1'b0);

    // Random handshakes with occasional aborts.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
Name: aes_dec_round_ctrl

Overview:
Round sequencer for the AES-128 decryptor datapath (InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, state register).
- Accepts one ciphertext block per valid/ready handshake.
- Drives the datapath mux select, round-key index and state write enable across the initial AddRoundKey, the middle rounds and the final round.
- Inserts wait cycles for the registered InvMixColumns stage.
- Presents completion on a valid/ready output handshake.

Parameters:
ROUNDS, 10, total decryption rounds; key index runs ROUNDS..0
IMC_LAT, 1, InvMixColumns register latency in cycles (≥1)
RK_W, 4, width of rk_idx; must hold ROUNDS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous abort; returns to IDLE
in_valid  in  1  ciphertext block available on datapath input
in_ready  out  1  controller can accept a block
out_valid  out  1  plaintext in datapath state register is final
out_ready  in  1  consumer takes plaintext
dp_load  out  1  datapath captures ciphertext (= in_valid & in_ready)
dp_sel  out  2  0=INIT (ct^rk), 1=ROUND (from InvMixColumns output), 2=FINAL (no InvMixColumns), 3=unused
rk_idx  out  RK_W  round-key index to key store
state_we  out  1  datapath state register write enable
busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, INIT, RND_ISSUE, RND_WAIT, FINAL, DONE. State, round counter (rnd) and wait counter (wcnt) are registered.
- Reset (rst=0, async): state=IDLE, rnd=0, wcnt=0.
  - Outputs in reset: in_ready=1, dp_load=0 (in_valid-gated), out_valid=0, state_we=0, dp_sel=0, rk_idx=0, busy=0.
- IDLE: in_ready=1. On in_valid → dp_load=1 the same cycle, next state INIT.
- INIT (1 cycle): dp_sel=0, rk_idx=ROUNDS, state_we=1. Load rnd=ROUNDS-1. Next RND_ISSUE.
- RND_ISSUE (1 cycle): dp_sel=1, rk_idx=rnd, state_we=0. InvMixColumns captures the ARK result. Load wcnt=IMC_LAT-1. Next RND_WAIT.
- RND_WAIT (IMC_LAT cycles): dp_sel=1, rk_idx=rnd. state_we=1 only when wcnt==0; otherwise decrement wcnt.
  - At wcnt==0 and rnd==1 → FINAL.
  - At wcnt==0 and rnd>1 → rnd-=1, RND_ISSUE.
- FINAL (1 cycle): dp_sel=2, rk_idx=0, state_we=1. Next DONE.
- DONE: out_valid=1; hold until out_ready, then IDLE. in_ready=0 in DONE (default build).
- Latency: handshake cycle T → out_valid first high at T+3+(ROUNDS-1)*(1+IMC_LAT). Defaults: T+21.
- Throughput (default build): one block per 21 cycles + out_ready stall + 1 IDLE cycle.
- Outputs are decoded from the registered state/rnd only. No combinational path from out_ready to out_valid. dp_load and in_ready are the only input-dependent outputs.
- in_valid is ignored outside IDLE; a held in_valid is not double-accepted.
- clr: highest priority. Next state IDLE, rnd=0, wcnt=0. Outputs in the clr cycle follow the current state. A block accepted in the same cycle as clr is discarded.
- out_valid must stay high, and rk_idx/dp_sel must stay stable, while out_ready=0.
- rk_idx never exceeds ROUNDS.
- Reset asserted mid-operation: immediate return to reset values; no partial out_valid.

Optional Feature:
AES_CTRL_OVERLAP_EN
- Defined: in DONE, in_ready=out_ready. If out_valid&out_ready&in_valid, the output completes and the new block is accepted (dp_load=1) in the same cycle. Next state INIT, skipping IDLE. Throughput becomes one block per 21 cycles.
- Undefined: in_ready=0 in DONE; IDLE cycle always inserted.

Test Plan:
- Reset then single block: in_valid pulse at T=5, out_ready=1 → dp_load at 5; out_valid at 26; state_we high at 6, at the 9 RND_WAIT cycles (8,10,…,24) and at 25; rk_idx sequence 10,9,9,8,8,…,1,1,0.
- FIPS-197 vector with real datapath, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102…0f → plaintext 00112233445566778899aabbccddeeff at out_valid.
- Backpressure: out_ready=0 for 7 cycles after out_valid → out_valid held, state_we=0, in_ready=0, in_valid ignored; release → IDLE next cycle, in_ready=1.
- clr asserted in RND_WAIT with rnd=5 → IDLE next cycle, busy=0, no out_valid; a following block completes with full 21-cycle latency.
- Async reset asserted during RND_ISSUE (rnd=3) → all outputs at reset values immediately, in_ready=1.
- With AES_CTRL_OVERLAP_EN, continuous in_valid and out_ready=1 → out_valid every 21 cycles, dp_load coincident with each out_valid.
